// File: rtl/inst_fetch_pkg.sv
// ----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared widths and constants for the instruction-fetch block.
//   INST_ADDR_BUS    : width of the PC / instruction address bus
//   INST_BUS         : width of an instruction word
//   RESET_PC_DEFAULT : PC loaded at reset (word aligned)
//   ZERO_INST        : instruction value presented when nothing is valid
// ----------------------------------------------------------------------------
package inst_fetch_pkg;

    localparam int          INST_ADDR_BUS    = 32;
    localparam int          INST_BUS         = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] ZERO_INST        = 32'h0000_0000;

endpackage : inst_fetch_pkg

// File: rtl/inst_fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding {pc, inst} prefetch entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write an entry (ignored when full unless popping too)
//   pop        : remove the head entry (ignored when empty)
//   flush      : empty the FIFO; wins over push and pop
//   dout       : head entry, all zeros when empty
//   count      : number of stored entries
//   full/empty : status flags
// ----------------------------------------------------------------------------
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = INST_ADDR_BUS + INST_BUS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

    assign w_do_pop  = pop & ~empty;
    // A full FIFO can still accept a write when the head leaves in the same cycle.
    assign w_do_push = push & (~full | w_do_pop);

    // Pointers are PTR_W bits wide and DEPTH is a power of two, so they wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout = empty ? '0 : r_mem[r_rd_ptr];

endmodule : fetch_fifo

// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch initiator: owns the PC, drives the ROM chip-enable and
// word address, captures each same-cycle ROM answer into a prefetch FIFO and
// presents the FIFO head to decode through a valid/ready handshake.
//   clk, rst_n              : clock, asynchronous active-low reset
//   rom_ce, rom_addr        : ROM fetch strobe and word index (pc >> 2)
//   rom_inst                : ROM data, valid in the cycle rom_ce=1
//   redirect_valid/_pc      : branch/jump redirect, flushes the FIFO
//   halt                    : stop issuing fetches, FIFO keeps draining
//   id_valid/id_ready       : decode handshake
//   id_inst, id_pc          : FIFO head (zero when id_valid=0)
// ----------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int               ADDR_W     = INST_ADDR_BUS,
    parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT[ADDR_W-1:0],
    parameter int               FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                rom_ce,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [INST_BUS-1:0] rom_inst,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                halt,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [INST_BUS-1:0] id_inst,
    output logic [ADDR_W-1:0]   id_pc
);

    localparam int ENTRY_W = ADDR_W + INST_BUS;

    logic [ADDR_W-1:0]           r_pc;
    logic                        w_pop;
    logic                        w_fetch_en;
    logic                        w_full;
    logic                        w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic [ENTRY_W-1:0]          w_dout;
    logic                        w_unused;

    assign w_pop = id_valid & id_ready;

    // rst_n gates the strobe so the ROM sees no fetch while reset is held,
    // even though an empty FIFO would otherwise request one.
    assign w_fetch_en = rst_n & ~redirect_valid & ~halt & (~w_full | w_pop);

    assign rom_ce   = w_fetch_en;
    assign rom_addr = w_fetch_en ? {2'b00, r_pc[ADDR_W-1:2]} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (w_fetch_en) begin
            r_pc <= r_pc + ADDR_W'(4);
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_fetch_en),
        .pop   (w_pop),
        .flush (redirect_valid),
        .din   ({r_pc, rom_inst}),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign id_valid = ~w_empty;
    assign id_pc    = w_dout[ENTRY_W-1:INST_BUS];
    assign id_inst  = w_dout[INST_BUS-1:0];

    // Occupancy is fully described by full/empty here; low redirect bits are forced to zero.
    assign w_unused = ^{w_count, redirect_pc[1:0]};

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    int n_checks = 0;
    int n_fail   = 0;

    inst_fetch #(
        .ADDR_W     (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_ce         (rom_ce),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: word i holds 32'h1000_0000 + i, answered combinationally.
    assign rom_inst = 32'h1000_0000 + rom_addr;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h1000_0000 + (pc >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit ce, input logic [31:0] addr,
                           input bit valid, input logic [31:0] pc);
        chk({tag, " rom_ce"},   {31'd0, rom_ce},   {31'd0, ce});
        chk({tag, " rom_addr"}, rom_addr,          addr);
        chk({tag, " id_valid"}, {31'd0, id_valid}, {31'd0, valid});
        chk({tag, " id_pc"},    id_pc,             valid ? pc : 32'h0);
        chk({tag, " id_inst"},  id_inst,           valid ? inst_of(pc) : 32'h0);
    endtask

    // ------------------------------------------------------------------
    // Reference model: queue of in-flight {pc, inst} plus the fetch PC.
    // ------------------------------------------------------------------
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t        mq[$];
    logic [31:0] mpc;

    task automatic model_reset();
        mq.delete();
        mpc = 32'h0;
    endtask

    // One cycle checked against the model; inputs must already be driven.
    task automatic model_step(input string tag);
        bit pop, fetch;
        pop   = (mq.size() > 0) && id_ready;
        fetch = !redirect_valid && !halt && ((mq.size() < 2) || pop);
        @(negedge clk);
        chk_all(tag, fetch, fetch ? (mpc >> 2) : 32'h0, mq.size() > 0,
                (mq.size() > 0) ? mq[0].pc : 32'h0);
        if (redirect_valid) begin
            mq.delete();
            mpc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (pop) void'(mq.pop_front());
            if (fetch) begin
                mq.push_back('{mpc, inst_of(mpc)});
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        id_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        #1;
        chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Directed vectors: inputs and hand-derived expected outputs per cycle.
    // ------------------------------------------------------------------
    typedef struct {
        bit          rst;
        bit          ready;
        bit          hlt;
        bit          redir;
        logic [31:0] rpc;
        bit          ce;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit ready, bit hlt, bit redir, logic [31:0] rpc,
                                bit ce, logic [31:0] addr, bit valid, logic [31:0] pc);
        vec_t v;
        v.rst = rst; v.ready = ready; v.hlt = hlt; v.redir = redir; v.rpc = rpc;
        v.ce = ce; v.addr = addr; v.valid = valid; v.pc = pc;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        id_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        //                  rst rdy hlt red rpc            ce addr           v  id_pc
        // back-pressure: two fetches then frozen
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,         1, 32'h0,          0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         1, 32'h1,          1, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 32'h0,          1, 32'h0));
        // redirect to 0x42 while full
        vecs.push_back(mk(0, 0, 0, 1, 32'h42,        0, 32'h0,          1, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         1, 32'h10,         0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'h11,         1, 32'h40));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'h12,         1, 32'h44));
        // fill to 2, then halt with id_ready=1
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         1, 32'h13,         1, 32'h48));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,         0, 32'h0,          1, 32'h48));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,         0, 32'h0,          1, 32'h4C));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,         0, 32'h0,          0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,         0, 32'h0,          0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'h14,         0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'h15,         1, 32'h50));
        // wrap around the top of the address space
        vecs.push_back(mk(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,          1, 32'h54));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'h3FFF_FFFF,  0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'h0,          1, 32'hFFFF_FFFC));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'h1,          1, 32'h0));
        // halt and redirect together
        vecs.push_back(mk(0, 1, 1, 1, 32'h100,       0, 32'h0,          1, 32'h4));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,         0, 32'h0,          0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'h40,         0, 32'h0));
        // back-to-back redirects: last wins, low bits forced to zero
        vecs.push_back(mk(0, 1, 0, 1, 32'h200,       0, 32'h0,          1, 32'h100));
        vecs.push_back(mk(0, 1, 0, 1, 32'h303,       0, 32'h0,          0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'hC0,         0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'hC1,         1, 32'h300));
        // streaming from reset with id_ready=1
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,         1, 32'h0,          0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'h1,          1, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'h2,          1, 32'h4));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 32'h3,          1, 32'h8));

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            id_ready       = vecs[i].ready;
            halt           = vecs[i].hlt;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            @(negedge clk);
            $display("vec %0d: ready=%0b halt=%0b redir=%0b rpc=%h -> ce=%0b addr=%h valid=%0b pc=%h",
                     i, id_ready, halt, redirect_valid, redirect_pc, rom_ce, rom_addr, id_valid, id_pc);
            chk_all($sformatf("vec%0d", i), vecs[i].ce, vecs[i].addr, vecs[i].valid, vecs[i].pc);
            @(posedge clk);
            #1;
        end

        // Randomised traffic against the queue model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            id_ready       = ($urandom_range(0, 9) < 7);
            halt           = ($urandom_range(0, 7) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                                         : $urandom();
            model_step($sformatf("rand%0d", c));
        end

        // Reset asserted between edges in the middle of a stream.
        id_ready = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
        for (int c = 0; c < 3; c++) model_step("stream");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset rom_ce",   {31'd0, rom_ce},   32'h0);
        chk("midreset id_valid", {31'd0, id_valid}, 32'h0);
        chk("midreset id_pc",    id_pc,             32'h0);
        chk("midreset rom_addr", rom_addr,          32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) model_step($sformatf("postreset%0d", c));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_inst_fetch
